spram_frame_reader: RTL and testbench
=====================================

SPRAM_FRAME_READER -- requirements
Module: spram_frame_reader

Interface
REQ-001 Parameter IMG_W, default 128, pixels per line (1..128).
REQ-002 Parameter IMG_H, default 120, lines per frame (1..128); IMG_W*IMG_H SHALL not exceed 16384.
REQ-003 clk  input  1  single clock for all logic; also drives the SPRAM CK pin.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 start  input  1  one-cycle pulse that begins reading one frame; ignored while busy.
REQ-006 busy  output  1  high from the cycle after an accepted start until the cycle after the last pixel handshake.
REQ-007 grant  input  1  arbiter permission; the SPRAM port is usable for a read this cycle only when high.
REQ-008 spram_ad  output  14  SPRAM word address.
REQ-009 spram_cs  output  1  SPRAM chip select; high only on cycles issuing a read.
REQ-010 spram_we  output  1  tied 0.
REQ-011 spram_maskwe  output  4  tied 4'b0000.
REQ-012 spram_do  input  16  SPRAM read data, valid exactly one clk after the issuing cycle.
REQ-013 pix_data  output  16  RGB565 pixel.
REQ-014 pix_valid  output  1  pix_data is valid.
REQ-015 pix_ready  input  1  downstream accepts; handshake when pix_valid and pix_ready are both high.
REQ-016 pix_sof  output  1  high with the first pixel of the frame (x=0, y=0).
REQ-017 pix_eol  output  1  high with the last pixel of each line (x=IMG_W-1).
REQ-018 frame_done  output  1  one-cycle pulse the cycle after the final pixel handshake.

Function
REQ-019 States SHALL be IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN when the last address (IMG_W*IMG_H-1) is issued; DRAIN->IDLE on the final pixel handshake.
REQ-020 Read address counter SHALL start at 0 and increment by 1 per issued read, linear raster order, no wrap within a frame.
REQ-021 A read SHALL be issued (spram_cs=1, spram_ad=counter) only when state=READ, grant=1, and (FIFO occupancy + reads in flight) < 2.
REQ-022 Returned data SHALL be captured into a 2-entry output FIFO one cycle after issue, regardless of grant or pix_ready on that cycle.
REQ-023 pix_valid SHALL equal FIFO not-empty; pix_data, pix_sof, pix_eol SHALL come from the FIFO head and stay stable while pix_valid=1 and pix_ready=0.
REQ-024 FIFO SHALL never overflow; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-025 Pixel x/y counters SHALL advance on each handshake; x wraps IMG_W-1->0 and increments y; both clear at frame end.
REQ-026 With grant=1 and pix_ready held high, throughput SHALL be one pixel per clk after a 2-cycle start latency (start at cycle N -> first pix_valid at cycle N+2).
REQ-027 grant low SHALL stall reads only; pending FIFO data SHALL continue to drain.
REQ-028 start asserted while busy SHALL be ignored with no effect on counters.
REQ-029 start and final handshake in the same cycle: start SHALL be ignored.

Reset
REQ-030 On reset: state=IDLE; address, x, y counters=0; FIFO empty; in-flight flag cleared.
REQ-031 Reset values: busy=0, spram_cs=0, spram_ad=0, pix_valid=0, pix_sof=0, pix_eol=0, frame_done=0, pix_data=0.
REQ-032 Reset mid-frame SHALL abort the frame without frame_done; data returning the cycle after reset SHALL be discarded.

Verification
REQ-033 IMG_W=4, IMG_H=2, memory word k=k+16'h100, grant=1, pix_ready=1, start pulse -> 8 pixels 0x100..0x107 on consecutive cycles, sof on first, eol on 4th and 8th, frame_done one cycle after 8th.
REQ-034 Same setup, pix_ready toggling 1/0 each cycle -> identical pixel sequence, no duplicate or lost pixel, spram_cs never issues a 3rd outstanding word.
REQ-035 grant low for 5 cycles mid-frame -> spram_cs=0 throughout, FIFO drains, reads resume at next address.
REQ-036 start pulsed again at pixel 3 -> ignored, single frame of 8 pixels, one frame_done.
REQ-037 reset at pixel 5 then new start -> output restarts at 0x100 with sof, no frame_done from aborted frame.
REQ-038 Default 128x120 full frame with random grant/pix_ready -> 15360 handshakes, last address 15359, 120 eol pulses.

Source files
------------

// File: rtl/spram_frame_reader.sv
// Streams one frame out of a single-port RAM as a valid/ready pixel stream.
// Reads are issued only while the arbiter grants the port, and never so far
// ahead that the 2-entry output FIFO could overflow.
module spram_frame_reader #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    input  logic        grant,
    output logic [13:0] spram_ad,
    output logic        spram_cs,
    output logic        spram_we,
    output logic [3:0]  spram_maskwe,
    input  logic [15:0] spram_do,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done
);

    localparam int unsigned AW = 14;
    localparam int unsigned XW = 7;
    localparam int unsigned YW = 7;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_addr;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [DW-1:0]   r_mem [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            r_inflight;
    logic            r_busy;
    logic            r_done;

    logic            w_pop;
    logic            w_issue;
    logic            w_last_pix;
    logic            w_frame_end;
    logic            w_start_ok;
    logic [CW-1:0]   w_credit;

    // Slot accounting counts this cycle's pop so a full-rate stream keeps one
    // word in the FIFO and one in flight without stalling.
    assign w_pop       = (r_count != 2'd0) && pix_ready;
    assign w_credit    = CW'(r_count) - CW'(w_pop) + CW'(r_inflight);
    assign w_issue     = (r_state == S_READ) && grant && (w_credit < CW'(2));
    assign w_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_frame_end = (r_state == S_DRAIN) && w_pop && w_last_pix;
    assign w_start_ok  = (r_state == S_IDLE) && start;

    assign spram_cs     = w_issue;
    assign spram_ad     = r_addr;
    assign spram_we     = 1'b0;
    assign spram_maskwe = 4'b0000;

    // The FIFO head is always the pixel at (r_x, r_y), so frame tags follow
    // directly from the handshake counters.
    assign pix_valid  = (r_count != 2'd0);
    assign pix_data   = r_mem[r_rd_ptr];
    assign pix_sof    = pix_valid && (r_x == '0) && (r_y == '0);
    assign pix_eol    = pix_valid && (r_x == X_LAST);
    assign busy       = r_busy;
    assign frame_done = r_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a start during a busy frame falls through untouched.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_READ;
            S_READ:  if (w_issue && (r_addr == LAST_ADDR)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_frame_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read address: linear raster order, held at the last word until frame end.
    always_ff @(posedge clk) begin
        if (reset || w_frame_end || w_start_ok) begin
            r_addr <= '0;
        end else if (w_issue && (r_addr != LAST_ADDR)) begin
            r_addr <= r_addr + AW'(1);
        end
    end

    // Output FIFO: capture returning read data one cycle after issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_mem[r_wr_ptr] <= spram_do;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

    // Pixel position of the FIFO head; wraps to (0,0) after the final pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pop) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Status flags: busy tracks the next state, done pulses after the last pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_spram_frame_reader.sv
// Scoreboard bench: a 4x2 instance exercises directed frame scenarios, and a
// default-size instance streams one full frame under random grant/ready.
module tb_spram_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_start, a_busy, a_grant, a_cs, a_we, a_valid, a_ready;
    logic        a_sof, a_eol, a_done;
    logic [13:0] a_ad;
    logic [3:0]  a_mwe;
    logic [15:0] a_do, a_data;

    logic        b_reset, b_start, b_busy, b_grant, b_cs, b_we, b_valid, b_ready;
    logic        b_sof, b_eol, b_done;
    logic [13:0] b_ad;
    logic [3:0]  b_mwe;
    logic [15:0] b_do, b_data;

    spram_frame_reader #(.IMG_W(4), .IMG_H(2)) u_a (
        .clk(clk), .reset(a_reset), .start(a_start), .busy(a_busy), .grant(a_grant),
        .spram_ad(a_ad), .spram_cs(a_cs), .spram_we(a_we), .spram_maskwe(a_mwe),
        .spram_do(a_do), .pix_data(a_data), .pix_valid(a_valid), .pix_ready(a_ready),
        .pix_sof(a_sof), .pix_eol(a_eol), .frame_done(a_done)
    );

    spram_frame_reader u_b (
        .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .grant(b_grant),
        .spram_ad(b_ad), .spram_cs(b_cs), .spram_we(b_we), .spram_maskwe(b_mwe),
        .spram_do(b_do), .pix_data(b_data), .pix_valid(b_valid), .pix_ready(b_ready),
        .pix_sof(b_sof), .pix_eol(b_eol), .frame_done(b_done)
    );

    // Memory models: word k holds k + 0x100, one cycle read latency.
    always @(posedge clk) if (a_cs) a_do <= a_ad + 16'h100;
    always @(posedge clk) if (b_cs) b_do <= b_ad + 16'h100;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          a_hs = 0, a_iss = 0, a_dcnt = 0;
    logic [13:0] a_exp_addr = '0;
    bit          a_pend = 0, a_hold = 0;
    logic [15:0] a_hold_data = '0;
    int          b_idx = 0, b_iss = 0, b_eols = 0, b_dcnt = 0;
    logic [13:0] b_last_ad = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flush();
        q.delete();
        a_hs = 0;
        a_iss = 0;
        a_exp_addr = '0;
        a_pend = 0;
        a_hold = 0;
    endtask

    // Monitor for the small instance: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        exp_t e;
        bit   hs;
        hs = a_valid && a_ready;
        if (a_done || a_pend) chk("frame_done", 32'(a_done), 32'(a_pend));
        if (a_done) a_dcnt++;
        a_pend = 0;
        if (!a_grant) chk("cs_without_grant", 32'(a_cs), 32'd0);
        if (a_cs) begin
            chk("read_addr", 32'(a_ad), 32'(a_exp_addr));
            chk("outstanding_le2", 32'((a_iss - a_hs - int'(hs) + 1) <= 2), 32'd1);
            a_exp_addr = a_exp_addr + 14'd1;
            a_iss++;
        end
        if (a_hold) begin
            chk("hold_valid", 32'(a_valid), 32'd1);
            chk("hold_data", 32'(a_data), 32'(a_hold_data));
        end
        a_hold      = a_valid && !a_ready;
        a_hold_data = a_data;
        if (hs) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pixel: got %0h expected none", a_data);
            end else begin
                e = q.pop_front();
                chk("pix_data", 32'(a_data), 32'(e.data));
                chk("pix_sof", 32'(a_sof), 32'(e.sof));
                chk("pix_eol", 32'(a_eol), 32'(e.eol));
                a_pend = e.last;
            end
            a_hs++;
        end
    end

    // Monitor for the full-size instance: checks each pixel against its index.
    always @(negedge clk) begin
        if (b_valid && b_ready) begin
            chk("full_pix", {14'd0, b_data, b_sof, b_eol},
                {14'd0, 16'(b_idx + 256), b_idx == 0, (b_idx % 128) == 127});
            if (b_eol) b_eols++;
            b_idx++;
        end
        if (b_cs) begin
            b_last_ad = b_ad;
            b_iss++;
        end
        if (b_done) b_dcnt++;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_cs"}, 32'(a_cs), 32'd0);
        chk({tag, "_ad"}, 32'(a_ad), 32'd0);
        chk({tag, "_valid"}, 32'(a_valid), 32'd0);
        chk({tag, "_sof_eol"}, {30'd0, a_sof, a_eol}, 32'd0);
        chk({tag, "_done"}, 32'(a_done), 32'd0);
        chk({tag, "_data"}, 32'(a_data), 32'd0);
    endtask

    // One 4x2 frame; optional ready toggling, grant gap, repeated start or reset.
    task automatic run_frame(input bit tog, input int gap_at, input int restart_hs,
                             input int reset_hs, input bit lat, input string tag);
        int d0;
        bit got;
        bit restarted;
        flush();
        for (int k = 0; k < 8; k++)
            q.push_back('{data: 16'(256 + k), sof: (k == 0), eol: ((k % 4) == 3), last: (k == 7)});
        d0 = a_dcnt;
        got = 0;
        restarted = 0;
        a_start = 1'b1;
        a_ready = 1'b1;
        a_grant = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(a_busy), 32'd1);
        for (int c = 0; c < 100 && !got; c++) begin
            if (lat && c <= 9) chk({tag, "_valid_timing"}, 32'(a_valid), 32'(c >= 2));
            a_ready = tog ? ~a_ready : 1'b1;
            a_grant = !(c >= gap_at && c < gap_at + 5);
            a_start = 1'b0;
            if (restart_hs >= 0 && !restarted && a_hs == restart_hs) begin
                a_start = 1'b1;
                restarted = 1;
            end
            if (reset_hs >= 0 && a_hs == reset_hs) begin
                a_reset = 1'b1;
                @(posedge clk); #1;
                a_reset = 1'b0;
                a_grant = 1'b1;
                flush();
                check_reset_vals({tag, "_abort"});
                repeat (3) @(posedge clk);
                #1;
                chk({tag, "_no_done_after_abort"}, 32'(a_dcnt - d0), 32'd0);
                return;
            end
            @(posedge clk); #1;
            got = (a_dcnt != d0);
        end
        a_start = 1'b0;
        a_grant = 1'b1;
        a_ready = 1'b1;
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no frame_done expected one", tag);
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_busy_idle"}, 32'(a_busy), 32'd0);
        chk({tag, "_done_count"}, 32'(a_dcnt - d0), 32'd1);
        chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
        chk({tag, "_no_extra"}, 32'(a_valid), 32'd0);
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_grant = 1'b1; b_grant = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;
        check_reset_vals("por");

        run_frame(0, 1000, -1, -1, 1, "basic");
        run_frame(1, 1000, -1, -1, 0, "toggle");
        run_frame(0, 3, -1, -1, 0, "gap");
        run_frame(0, 1000, 3, -1, 0, "restart");
        run_frame(0, 1000, -1, 5, 0, "reset");
        run_frame(0, 1000, -1, -1, 0, "after_reset");

        // Full default-size frame with random arbitration and back-pressure.
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int c = 0; c < 80000 && b_dcnt == 0; c++) begin
            b_grant = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        b_ready = 1'b1;
        if (b_dcnt == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL full_timeout: got no frame_done expected one");
        end
        repeat (3) @(posedge clk);
        #1;
        chk("full_handshakes", 32'(b_idx), 32'd15360);
        chk("full_reads", 32'(b_iss), 32'd15360);
        chk("full_last_addr", 32'(b_last_ad), 32'd15359);
        chk("full_eol_count", 32'(b_eols), 32'd120);
        chk("full_done_count", 32'(b_dcnt), 32'd1);
        chk("full_busy_idle", 32'(b_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
